// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: line timing common to the transmitter and the
// receiver, the receiver state encoding and the GRB word size.
package ws2812b_pkg;

    localparam int CYCLES_SHORT = 3;
    localparam int CYCLES_LONG  = 5;
    localparam int CYCLES_RET   = 450;

    localparam int RX_CYCLES_BIT_THRESHOLD = CYCLES_SHORT + 2;
    localparam int RX_CYCLES_RESET         = CYCLES_RET / 2;

    localparam int WORD_BITS = 24;

    typedef enum logic [1:0] {
        WAIT_GAP,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;

endpackage

// File: rtl/ws2812b_rx_sync.sv
// Brings the asynchronous WS2812B line into the clk domain and derives
// single-cycle rise/fall strobes from the synchronized level.
module ws2812b_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic i_data,
    output logic o_data_s,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_data_s;
    logic r_data_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_meta   <= 1'b0;
            r_data_s <= 1'b0;
            r_data_q <= 1'b0;
        end else begin
            r_meta   <= i_data;
            r_data_s <= r_meta;
            r_data_q <= r_data_s;
        end
    end

    assign o_data_s = r_data_s;
    assign o_rise   = r_data_s & ~r_data_q;
    assign o_fall   = ~r_data_s & r_data_q;

endmodule

// File: rtl/ws2812b_rx_module.sv
// WS2812B receiver: decodes NRZ high-pulse widths into 24-bit GRB words and
// hands them out over valid/ready, flagging latch gaps and framing errors.
module ws2812b_rx_module
    import ws2812b_pkg::*;
#(
    parameter int CYCLES_BIT_THRESHOLD = RX_CYCLES_BIT_THRESHOLD,
    parameter int CYCLES_MAX_HIGH      = 32,
    parameter int CYCLES_RESET         = 200,
    parameter int CNT_WIDTH            = $clog2(CYCLES_RESET + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_ws2812b_data,
    output logic [WORD_BITS-1:0] o_word_out,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic                 o_frame_end,
    output logic                 o_err_partial,
    output logic                 o_err_pulse,
    output logic                 o_overrun
);

    localparam int BN_WIDTH = $clog2(WORD_BITS);

    localparam logic [CNT_WIDTH-1:0] C_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_THRESH   = CNT_WIDTH'(CYCLES_BIT_THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] C_MAX_HIGH = CNT_WIDTH'(CYCLES_MAX_HIGH);
    localparam logic [CNT_WIDTH-1:0] C_GAP_LAST = CNT_WIDTH'(CYCLES_RESET - 1);
    localparam logic [CNT_WIDTH-1:0] C_RESET    = CNT_WIDTH'(CYCLES_RESET);
    localparam logic [BN_WIDTH-1:0]  C_LAST_BIT = BN_WIDTH'(WORD_BITS - 1);

    logic w_data_s;
    logic w_rise;
    logic w_fall;
    logic w_bit;
    logic w_slot_free;
    logic [WORD_BITS-1:0] w_shreg_next;

    rx_state_t              r_state;
    logic [CNT_WIDTH-1:0]   r_counter;
    logic [BN_WIDTH-1:0]    r_bitnum;
    logic [WORD_BITS-1:0]   r_shreg;
    logic [WORD_BITS-1:0]   r_word_out;
    logic                   r_word_valid;
    logic                   r_frame_end;
    logic                   r_err_partial;
    logic                   r_err_pulse;
    logic                   r_overrun;

    ws2812b_rx_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .i_data   (i_ws2812b_data),
        .o_data_s (w_data_s),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    assign w_bit        = (r_counter >= C_THRESH);
    assign w_shreg_next = {r_shreg[WORD_BITS-2:0], w_bit};
    // A finished word may be loaded when the slot is empty or drains this cycle.
    assign w_slot_free  = ~r_word_valid | i_word_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= WAIT_GAP;
            r_counter     <= '0;
            r_bitnum      <= '0;
            r_shreg       <= '0;
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
            r_frame_end   <= 1'b0;
            r_err_partial <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_end   <= 1'b0;
            r_err_partial <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_overrun     <= 1'b0;

            if (r_word_valid && i_word_ready) begin
                r_word_valid <= 1'b0;
            end

            case (r_state)
                // Only arm the decoder after a full latch gap so a stream
                // joined mid-word is never decoded.
                WAIT_GAP: begin
                    if (w_data_s) begin
                        r_counter <= '0;
                    end else if (r_counter == C_GAP_LAST) begin
                        r_counter <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_counter <= r_counter + C_ONE;
                    end
                end

                IDLE: begin
                    if (w_rise) begin
                        r_counter <= C_ONE;
                        r_state   <= HIGH;
                    end
                end

                HIGH: begin
                    if (w_fall) begin
                        r_shreg   <= w_shreg_next;
                        r_counter <= C_ONE;
                        r_state   <= LOW;
                        if (r_bitnum == C_LAST_BIT) begin
                            r_bitnum <= '0;
                            if (w_slot_free) begin
                                r_word_out   <= w_shreg_next;
                                r_word_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_bitnum <= r_bitnum + 1'b1;
                        end
                    end else if (r_counter > C_MAX_HIGH) begin
                        r_err_pulse <= 1'b1;
                        r_shreg     <= '0;
                        r_bitnum    <= '0;
                        r_counter   <= '0;
                        r_state     <= WAIT_GAP;
                    end else begin
                        r_counter <= r_counter + C_ONE;
                    end
                end

                LOW: begin
                    if (w_rise) begin
                        r_counter <= C_ONE;
                        r_state   <= HIGH;
                    end else if (r_counter == C_RESET) begin
                        r_frame_end <= 1'b1;
                        if (r_bitnum != '0) begin
                            r_err_partial <= 1'b1;
                            r_bitnum      <= '0;
                        end
                        r_counter <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_counter <= r_counter + C_ONE;
                    end
                end

                default: begin
                    r_counter <= '0;
                    r_state   <= WAIT_GAP;
                end
            endcase
        end
    end

    assign o_word_out    = r_word_out;
    assign o_word_valid  = r_word_valid;
    assign o_frame_end   = r_frame_end;
    assign o_err_partial = r_err_partial;
    assign o_err_pulse   = r_err_pulse;
    assign o_overrun     = r_overrun;

endmodule
